// File: rtl/clock_seq_pkg.sv
// Shared types and constants for the clock sequencer.
//   state_t   : sequencer FSM states
//   OP_*      : host command op codes carried on i_cmd_op
//   ready_in  : states in which a new command may be accepted
package clock_seq_pkg;

  localparam int unsigned OP_WIDTH = 2;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUN      = 2'd1,
    STEP     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_NOP  = 2'b00;
  localparam logic [OP_WIDTH-1:0] OP_RUN  = 2'b01;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 2'b10;
  localparam logic [OP_WIDTH-1:0] OP_STEP = 2'b11;

  // Commands are only taken while the clock is either parked or free-running.
  function automatic logic ready_in(input state_t s);
    return (s == HALTED) || (s == RUN);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rise/fall detector for a signal already in the i_clk domain.
//   i_clk, i_rst : system clock, async active-high reset
//   i_in         : sampled signal (generated clock)
//   o_rise       : i_in high now, low last cycle
//   o_fall       : i_in low now, high last cycle
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_rise,
  output logic o_fall
);

  logic gen_q;
  logic gen_d;

  assign gen_d = i_in;

  // Previous-cycle copy of the input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gen_q <= 1'b0;
    end else begin
      gen_q <= gen_d;
    end
  end

  // Combinational so the sequencer reacts in the same cycle the edge is visible.
  assign o_rise = i_in & ~gen_q;
  assign o_fall = ~i_in & gen_q;

endmodule

// File: rtl/clock_sequencer.sv
// Run/halt/single-step controller for one divided clock.
// Drives the clock block's stop input and watches its output so the clock can
// free-run, be parked cleanly in its low phase, or emit exactly N cycles.
//   i_clk, i_rst  : system clock, async active-high reset
//   i_cmd_valid   : command valid
//   o_cmd_ready   : command ready (HALTED or RUN); transfer = valid & ready
//   i_cmd_op      : NOP / RUN / HALT / STEP
//   i_cmd_count   : STEP cycle count N
//   i_gen_clk     : generated clock from the clock block
//   o_stop        : freeze request to the clock block (1 = frozen)
//   o_running     : sequencer is not HALTED
//   o_done        : one-cycle pulse when HALT or STEP completes
//   o_cycles      : generated-clock rising edges since reset (wrapping)
module clock_sequencer
  import clock_seq_pkg::*;
#(
  parameter int unsigned p_count_width  = 16,
  parameter int unsigned p_cycles_width = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [OP_WIDTH-1:0]       i_cmd_op,
  input  logic [p_count_width-1:0]  i_cmd_count,
  input  logic                      i_gen_clk,
  output logic                      o_stop,
  output logic                      o_running,
  output logic                      o_done,
  output logic [p_cycles_width-1:0] o_cycles
);

  state_t                     state_q,     state_d;
  logic [p_count_width-1:0]   remaining_q, remaining_d;
  logic [p_cycles_width-1:0]  cycles_q,    cycles_d;
  logic                       stop_q,      stop_d;
  logic                       running_q,   running_d;
  logic                       done_q,      done_d;
  logic                       ready_q,     ready_d;

  logic rise;
  logic fall;
  logic cmd_xfer;

  // Edge register for the generated clock.
  edge_detect u_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_in   (i_gen_clk),
    .o_rise (rise),
    .o_fall (fall)
  );

  assign cmd_xfer = i_cmd_valid & ready_q;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cycles_d    = cycles_q;
    done_d      = 1'b0;

    // Edge count runs in every state, including across command transfers.
    if (rise) begin
      cycles_d = cycles_q + p_cycles_width'(1);
    end

    unique case (state_q)
      HALTED: begin
        if (cmd_xfer) begin
          unique case (i_cmd_op)
            OP_RUN: state_d = RUN;
            OP_STEP: begin
              if (i_cmd_count != '0) begin
                state_d     = STEP;
                remaining_d = i_cmd_count;
              end else begin
                done_d = 1'b1;
              end
            end
            OP_HALT: done_d = 1'b1;
            OP_NOP:  ;
          endcase
        end
      end

      RUN: begin
        // A rise coinciding with a STEP transfer is not charged against N.
        if (cmd_xfer) begin
          unique case (i_cmd_op)
            OP_HALT: state_d = STOPPING;
            OP_STEP: begin
              if (i_cmd_count != '0) begin
                state_d     = STEP;
                remaining_d = i_cmd_count;
              end else begin
                state_d = STOPPING;
              end
            end
            OP_RUN:  ;
            OP_NOP:  ;
          endcase
        end
      end

      STEP: begin
        if (rise) begin
          remaining_d = remaining_q - p_count_width'(1);
          if (remaining_q == p_count_width'(1)) begin
            state_d = STOPPING;
          end
        end
      end

      STOPPING: begin
        // Only freeze after a fall so the clock always parks low.
        if (fall) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end
      end

      default: state_d = HALTED;
    endcase

    stop_d    = (state_d == HALTED);
    running_d = (state_d != HALTED);
    ready_d   = ready_in(state_d);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= HALTED;
      remaining_q <= '0;
      cycles_q    <= '0;
      stop_q      <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cycles_q    <= cycles_d;
      stop_q      <= stop_d;
      running_q   <= running_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_stop      = stop_q;
  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_cycles    = cycles_q;

endmodule
